data_memory_port: RTL and testbench

Memory-stage load/store port sitting between the execute/memory pipeline registers and the single-ported data memory; it is the store-side and request-side counterpart of the writeback load path. It takes the effective address, store data and access width from the M stage and aligns them into a word-addressed, byte-enabled request. It runs a request/ready handshake with the memory and stalls the pipeline while the access is outstanding. It returns the read word shifted to byte lane 0, zero-filled, so the writeback stage performs sign/zero extension.

---
 rtl/data_memory_port.sv | 164 ++++++++++++++++
 tb/tb_data_memory_port.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_port.sv
// Memory-stage load/store port: aligns M-stage accesses into word-addressed, byte-enabled
// requests, handshakes with the data memory and returns lane-0-aligned, zero-filled load data.
`timescale 1ns/1ps
module data_memory_port #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] StoreDataM,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    output logic        MemWe,
    output logic        MemReq,
    input  logic        MemReady,
    input  logic [31:0] MemRData,
    output logic [31:0] DataMemOutM,
    output logic        StallM,
    output logic        AccessDoneM,
    output logic        MisalignedM,
    output logic        BusErrorM
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic [1:0]  r_width;
    logic [1:0]  r_off;
    logic [31:0] r_dout;
    logic        r_buserr;

    logic        w_idle;
    logic        w_op;
    logic [1:0]  w_width;
    logic        w_mis;
    logic        w_access;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;
    logic [7:0]  w_cnt_next;
    logic        w_unused_funct3;

    // Signed/unsigned load variants share a width; extension happens in writeback.
    assign w_width         = Funct3M[1:0];
    assign w_unused_funct3 = Funct3M[2];

    assign w_idle   = (r_state == S_IDLE);
    assign w_op     = MemReadM | MemWriteM;
    assign w_mis    = ((w_width == 2'b01) & ALUOutM[0]) |
                      (w_width[1] & (ALUOutM[1:0] != 2'b00));
    assign w_access = w_idle & w_op & ~w_mis;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = StoreDataM;
        case (w_width)
            2'b00: begin
                w_be    = 4'b0001 << ALUOutM[1:0];
                w_wdata = {4{StoreDataM[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {ALUOutM[1], 1'b0};
                w_wdata = {2{StoreDataM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = StoreDataM;
            end
        endcase
    end

    assign w_shifted = MemRData >> {r_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_width)
            2'b00:   w_load = {24'd0, w_shifted[7:0]};
            2'b01:   w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    assign w_cnt_next = r_cnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_be     <= 4'd0;
            r_we     <= 1'b0;
            r_width  <= 2'd0;
            r_off    <= 2'd0;
            r_dout   <= 32'd0;
            r_buserr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_buserr <= 1'b0;
                    if (w_access) begin
                        r_addr  <= {ALUOutM[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_we    <= MemWriteM;
                        r_width <= w_width;
                        r_off   <= ALUOutM[1:0];
                        r_cnt   <= 8'd0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Ready takes priority over an expiring timeout on the same edge.
                    if (MemReady) begin
                        if (!r_we) begin
                            r_dout <= w_load;
                        end
                        r_state <= S_DONE;
                    end else if (w_cnt_next == LP_TIMEOUT) begin
                        r_cnt    <= w_cnt_next;
                        r_buserr <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_DONE: begin
                    r_buserr <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_buserr <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign MemAddr     = r_addr;
    assign MemWData    = r_wdata;
    assign MemByteEn   = r_be;
    assign MemWe       = r_we;
    assign MemReq      = (r_state == S_REQ);
    assign DataMemOutM = r_dout;
    assign AccessDoneM = (r_state == S_DONE);
    assign BusErrorM   = r_buserr;
    assign MisalignedM = w_idle & w_op & w_mis;
    assign StallM      = w_access | (r_state == S_REQ);

endmodule

// File: tb/tb_data_memory_port.sv
// Bench for data_memory_port: scoreboard of expected access completions checked by a monitor,
// with a randomized memory responder and a spec-level reference model.
`timescale 1ns/1ps
module tb_data_memory_port;

    localparam int TP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUOutM, StoreDataM;
    logic [31:0] MemAddr, MemWData, MemRData, DataMemOutM;
    logic [3:0]  MemByteEn;
    logic        MemWe, MemReq, MemReady;
    logic        StallM, AccessDoneM, MisalignedM, BusErrorM;

    data_memory_port #(.TIMEOUT(TP)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUOutM(ALUOutM), .StoreDataM(StoreDataM),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemByteEn(MemByteEn), .MemWe(MemWe),
        .MemReq(MemReq), .MemReady(MemReady), .MemRData(MemRData),
        .DataMemOutM(DataMemOutM), .StallM(StallM), .AccessDoneM(AccessDoneM),
        .MisalignedM(MisalignedM), .BusErrorM(BusErrorM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] dout;
        logic        buserr;
        int          stall;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_dout = 32'd0;
    int          rsp_wait = 0;
    logic [31:0] rsp_data = 32'd0;
    int          rsp_cnt  = 0;
    int          stall_cnt = 0;
    logic [2:0]  f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: ready after rsp_wait low cycles in a request; noise outside requests.
    initial begin
        MemReady = 1'b0;
        MemRData = 32'd0;
        forever begin
            @(negedge clk);
            if (MemReq) begin
                if (rsp_cnt == rsp_wait) begin
                    MemReady = 1'b1;
                    MemRData = rsp_data;
                end else begin
                    MemReady = 1'b0;
                    MemRData = $urandom;
                end
                rsp_cnt++;
            end else begin
                rsp_cnt  = 0;
                MemReady = 1'($urandom_range(0, 1));
                MemRData = $urandom;
            end
        end
    end

    // Monitor: every completion is matched against the oldest expected access.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
            end else begin
                if (StallM) stall_cnt++;
                if (MemReq && MisalignedM) check("mis_in_req", 32'(MisalignedM), 32'd0);
                if (BusErrorM && !AccessDoneM) check("buserr_alone", 32'(AccessDoneM), 32'd1);
                if (AccessDoneM) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'(AccessDoneM), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("addr", MemAddr, e.addr);
                        check("wdata", MemWData, e.wdata);
                        check("byteen", 32'(MemByteEn), 32'(e.be));
                        check("we", 32'(MemWe), 32'(e.we));
                        check("dout", DataMemOutM, e.dout);
                        check("buserr", 32'(BusErrorM), 32'(e.buserr));
                        check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                        check("req_in_done", 32'(MemReq), 32'd0);
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic drive_idle();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'($urandom);
        ALUOutM    = $urandom;
        StoreDataM = $urandom;
    endtask

    task automatic do_op(input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input int wt, input logic [31:0] rdata);
        int   off;
        int   nbytes;
        bit   mis;
        bit   done;
        exp_t e;
        off    = int'(addr[1:0]);
        nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis    = (addr % nbytes) != 0;
        MemReadM   = rd;
        MemWriteM  = ~rd;
        Funct3M    = f3;
        ALUOutM    = addr;
        StoreDataM = sd;
        if (mis) begin
            repeat (2) begin
                #1;
                check("misaligned", 32'(MisalignedM), 32'd1);
                check("mis_req", 32'(MemReq), 32'd0);
                check("mis_stall", 32'(StallM), 32'd0);
                @(posedge clk);
            end
            #1;
            drive_idle();
            return;
        end
        e.addr = addr - 32'(off);
        e.we   = ~rd;
        if (nbytes == 1) begin
            e.be    = 4'(1 << off);
            e.wdata = (sd & 32'hFF) * 32'h0101_0101;
        end else if (nbytes == 2) begin
            e.be    = 4'(3 << off);
            e.wdata = (sd & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.be    = 4'hF;
            e.wdata = sd;
        end
        if (wt < TP) begin
            e.buserr = 1'b0;
            e.stall  = 1 + wt + 1;
            if (rd) begin
                if (nbytes == 4) model_dout = rdata;
                else model_dout = (rdata >> (8 * off)) % (32'd1 << (8 * nbytes));
            end
        end else begin
            e.buserr = 1'b1;
            e.stall  = 1 + TP;
        end
        e.dout   = model_dout;
        rsp_wait = wt;
        rsp_data = rdata;
        sb_q.push_back(e);
        done = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (AccessDoneM) begin
                done = 1;
                break;
            end
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    initial begin
        bit ok;
        reset = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(MemReq), 32'd0);
        check("rst_addr", MemAddr, 32'd0);
        check("rst_dout", DataMemOutM, 32'd0);
        check("rst_done", 32'(AccessDoneM), 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op(1'b0, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 32'd0);
        do_op(1'b1, 3'b101, 32'h0000_2002, 32'd0, 3, 32'h8765_4321);
        do_op(1'b1, 3'b010, 32'h0000_3001, 32'd0, 0, 32'd0);
        do_op(1'b1, 3'b010, 32'h0000_4000, 32'd0, 1000, 32'hDEAD_BEEF);
        do_op(1'b1, 3'b000, 32'h0000_5000, 32'd0, TP - 1, 32'h1234_5678);
        do_op(1'b1, 3'b010, 32'h0000_6004, 32'd0, 0, 32'hCAFE_F00D);
        do_op(1'b0, 3'b001, 32'h0000_6006, 32'h1111_BEEF, 1, 32'd0);

        // Abandon a request by resetting while it waits.
        rsp_wait   = 1000;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b010;
        ALUOutM    = 32'h0000_7000;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (MemReq) begin
                ok = 1;
                break;
            end
        end
        check("reach_req", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
        reset    = 1'b1;
        MemReadM = 1'b0;
        #1;
        check("midrst_req", 32'(MemReq), 32'd0);
        check("midrst_addr", MemAddr, 32'd0);
        check("midrst_wdata", MemWData, 32'd0);
        check("midrst_be", 32'(MemByteEn), 32'd0);
        check("midrst_we", 32'(MemWe), 32'd0);
        check("midrst_dout", DataMemOutM, 32'd0);
        check("midrst_done", 32'(AccessDoneM), 32'd0);
        check("midrst_buserr", 32'(BusErrorM), 32'd0);
        check("midrst_stall", 32'(StallM), 32'd0);
        model_dout = 32'd0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;

        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            f3 = f3_tab[$urandom_range(0, 4)];
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if ($urandom_range(0, 5) == 0) begin
                drive_idle();
                @(posedge clk);
                #1;
            end else begin
                do_op(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 6), $urandom);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
